// File: rtl/dda_pkg.sv
// rtl/dda_pkg.sv - shared constants, opcodes and FSM states for the dda SPI command stage
package dda_pkg;

    localparam int DDA_N    = 16;
    localparam int REG_SIZE = 4;

    localparam logic [1:0] OP_RD_STATE = 2'b00;
    localparam logic [1:0] OP_WR_PARAM = 2'b01;
    localparam logic [1:0] OP_RD_PARAM = 2'b10;
    localparam logic [1:0] OP_CTRL     = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_HI,
        WR_LO,
        WR_CK,
        STREAM
    } state_t;

    localparam logic [15:0] ICX_RST = 16'hC000;
    localparam logic [15:0] ICY_RST = 16'h14CD;
    localparam logic [15:0] K_RST   = 16'h14DD;
    localparam logic [15:0] D_RST   = 16'h14DD;

    function automatic logic [15:0] param_rst(input logic [1:0] idx);
        case (idx)
            2'd0:    return ICX_RST;
            2'd1:    return ICY_RST;
            2'd2:    return K_RST;
            default: return D_RST;
        endcase
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser, resets to 1 (idle chip select)
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dda_spi_ctrl.sv
// rtl/dda_spi_ctrl.sv - SPI byte decoder: parameter writes, run control, state/parameter reads
// Optional DDA_SPI_CHECKSUM_EN: XOR checksum byte on reads, checked third byte on writes.
module dda_spi_ctrl
    import dda_pkg::*;
#(
    parameter int N = DDA_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         spi_cs_n,
    input  logic         rx_dv,
    input  logic [7:0]   rx_byte,
    output logic         tx_dv,
    output logic [7:0]   tx_byte,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] icx,
    output logic [N-1:0] icy,
    output logic [N-1:0] k,
    output logic [N-1:0] d,
    output logic         en_dda,
    output logic         dda_restart
);

`ifdef DDA_SPI_CHECKSUM_EN
    localparam logic [2:0] CK_LEN = 3'd1;
`else
    localparam logic [2:0] CK_LEN = 3'd0;
`endif

    state_t         state_q, state_d;
    logic [N-1:0]   param_q [REG_SIZE];
    logic [N-1:0]   param_d [REG_SIZE];
    logic [2*N-1:0] snap_q, snap_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           is_state_q, is_state_d;
    logic [1:0]     wr_idx_q, wr_idx_d;
    logic           wr_bad_q, wr_bad_d;
    logic [7:0]     wr_hi_q, wr_hi_d;
    logic [7:0]     wr_lo_q, wr_lo_d;
    logic           en_q, en_d;
    logic           restart_q, restart_d;
    logic           err_q, err_d;
    logic           tx_dv_q, tx_dv_d;
    logic [7:0]     tx_byte_q, tx_byte_d;

    logic           cs_sync;
    logic           err_set;
    logic           use_status;
    logic [2:0]     data_len;
    logic [2:0]     stream_len;
    logic [N-1:0]   rd_param;
    logic [7:0]     snap_xor;

    sync2 u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_cs_n),
        .q     (cs_sync)
    );

    assign data_len   = is_state_q ? 3'd4 : 3'd2;
    assign stream_len = data_len + CK_LEN;
    assign rd_param   = param_q[rx_byte[1:0]];
    // Parameter snapshots carry a zero low word, so the same 4-byte XOR serves both reads.
    assign snap_xor   = snap_q[2*N-1 -: 8] ^ snap_q[2*N-9 -: 8] ^ snap_q[N-1 -: 8] ^ snap_q[7:0];

    always_comb begin
        state_d    = state_q;
        param_d    = param_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        is_state_d = is_state_q;
        wr_idx_d   = wr_idx_q;
        wr_bad_d   = wr_bad_q;
        wr_hi_d    = wr_hi_q;
        wr_lo_d    = wr_lo_q;
        en_d       = en_q;
        restart_d  = 1'b0;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        err_set    = 1'b0;
        use_status = 1'b0;

        if (cs_sync) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else if (rx_dv) begin
            tx_dv_d = 1'b1;
            case (state_q)
                IDLE: begin
                    case (rx_byte[7:6])
                        OP_RD_STATE: begin
                            snap_d     = {x, y};
                            is_state_d = 1'b1;
                            cnt_d      = 3'd1;
                            state_d    = STREAM;
                            tx_byte_d  = x[N-1 -: 8];
                        end
                        OP_WR_PARAM: begin
                            wr_idx_d   = rx_byte[1:0];
                            wr_bad_d   = rx_byte[5:0] >= 6'(REG_SIZE);
                            state_d    = WR_HI;
                            use_status = 1'b1;
                        end
                        OP_RD_PARAM: begin
                            snap_d     = {rd_param, {N{1'b0}}};
                            is_state_d = 1'b0;
                            cnt_d      = 3'd1;
                            state_d    = STREAM;
                            tx_byte_d  = rd_param[N-1 -: 8];
                        end
                        default: begin
                            en_d       = rx_byte[0];
                            restart_d  = rx_byte[1];
                            use_status = 1'b1;
                        end
                    endcase
                end
                WR_HI: begin
                    wr_hi_d    = rx_byte;
                    state_d    = WR_LO;
                    use_status = 1'b1;
                end
                WR_LO: begin
                    use_status = 1'b1;
`ifdef DDA_SPI_CHECKSUM_EN
                    wr_lo_d = rx_byte;
                    state_d = WR_CK;
`else
                    state_d = IDLE;
                    if (wr_bad_q) begin
                        err_set = 1'b1;
                    end else begin
                        param_d[wr_idx_q] = {wr_hi_q, rx_byte};
                    end
`endif
                end
                WR_CK: begin
                    use_status = 1'b1;
                    state_d    = IDLE;
                    if (!wr_bad_q && rx_byte == (wr_hi_q ^ wr_lo_q)) begin
                        param_d[wr_idx_q] = {wr_hi_q, wr_lo_q};
                    end else begin
                        err_set = 1'b1;
                    end
                end
                STREAM: begin
                    if (cnt_q == stream_len) begin
                        use_status = 1'b1;
                        state_d    = IDLE;
                        cnt_d      = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == data_len) begin
                            tx_byte_d = snap_xor;
                        end else begin
                            case (cnt_q)
                                3'd1:    tx_byte_d = snap_q[2*N-9 -: 8];
                                3'd2:    tx_byte_d = snap_q[N-1 -: 8];
                                default: tx_byte_d = snap_q[7:0];
                            endcase
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A STATUS reply reports any error raised by this same byte, then clears it.
        err_d = err_q | err_set;
        if (use_status) begin
            tx_byte_d = {en_d, 6'b0, err_d};
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            for (int i = 0; i < REG_SIZE; i++) begin
                param_q[i] <= param_rst(2'(i));
            end
            snap_q     <= '0;
            cnt_q      <= 3'd0;
            is_state_q <= 1'b0;
            wr_idx_q   <= 2'd0;
            wr_bad_q   <= 1'b0;
            wr_hi_q    <= 8'h00;
            wr_lo_q    <= 8'h00;
            en_q       <= 1'b1;
            restart_q  <= 1'b0;
            err_q      <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            param_q    <= param_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            is_state_q <= is_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_bad_q   <= wr_bad_d;
            wr_hi_q    <= wr_hi_d;
            wr_lo_q    <= wr_lo_d;
            en_q       <= en_d;
            restart_q  <= restart_d;
            err_q      <= err_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign icx         = param_q[0];
    assign icy         = param_q[1];
    assign k           = param_q[2];
    assign d           = param_q[3];
    assign en_dda      = en_q;
    assign dda_restart = restart_q;
    assign tx_dv       = tx_dv_q;
    assign tx_byte     = tx_byte_q;

endmodule

// File: tb/tb_dda_spi_ctrl.sv
// tb/tb_dda_spi_ctrl.sv - randomized frame-level bench for dda_spi_ctrl against a byte-stream reference model
module tb_dda_spi_ctrl;

`ifdef DDA_SPI_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_cs_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [15:0] x, y;
    logic [15:0] icx, icy, k, d;
    logic        en_dda;
    logic        dda_restart;

    always #5 clk = ~clk;

    dda_spi_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_cs_n    (spi_cs_n),
        .rx_dv       (rx_dv),
        .rx_byte     (rx_byte),
        .tx_dv       (tx_dv),
        .tx_byte     (tx_byte),
        .x           (x),
        .y           (y),
        .icx         (icx),
        .icy         (icy),
        .k           (k),
        .d           (d),
        .en_dda      (en_dda),
        .dda_restart (dda_restart)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] m_param [4];
    logic        m_en;
    logic        m_err;
    int          m_restarts = 0;
    int          rs_obs = 0;

    logic [7:0]  fb[$];
    logic [7:0]  obs[$];
    logic [7:0]  expq[$];
    logic [15:0] fx[$];
    logic [15:0] fy[$];

    always @(negedge clk) if (dda_restart === 1'b1) rs_obs++;

    task automatic model_reset();
        m_param = '{16'hC000, 16'h14CD, 16'h14DD, 16'h14DD};
        m_en    = 1'b1;
        m_err   = 1'b0;
    endtask

    function automatic logic [7:0] status_rd();
        logic [7:0] s;
        s     = {m_en, 6'b0, m_err};
        m_err = 1'b0;
        return s;
    endfunction

    // Walks a CS frame command by command and produces the reply expected for every byte.
    task automatic model_frame();
        int          i;
        int          n;
        logic [7:0]  c, hi, lo, s;
        logic [15:0] p;
        logic        ok;
        logic [7:0]  data[$];
        expq.delete();
        i = 0;
        while (i < fb.size()) begin
            c = fb[i];
            if (c[6] == 1'b0) begin
                data.delete();
                if (c[7] == 1'b0) begin
                    data.push_back(fx[i][15:8]);
                    data.push_back(fx[i][7:0]);
                    data.push_back(fy[i][15:8]);
                    data.push_back(fy[i][7:0]);
                end else begin
                    p = m_param[c[1:0]];
                    data.push_back(p[15:8]);
                    data.push_back(p[7:0]);
                end
                if (CK == 1) begin
                    s = 8'h00;
                    foreach (data[j]) s = s ^ data[j];
                    data.push_back(s);
                end
                for (int j = 0; j <= data.size(); j++) begin
                    if (i + j < fb.size()) begin
                        if (j < data.size()) expq.push_back(data[j]);
                        else expq.push_back(status_rd());
                    end
                end
                i += data.size() + 1;
            end else if (c[7] == 1'b0) begin
                n = 2 + CK;
                expq.push_back(status_rd());
                for (int j = 1; j <= n; j++) begin
                    if (i + j < fb.size()) begin
                        if (j == n) begin
                            hi = fb[i+1];
                            lo = fb[i+2];
                            ok = (c[5:0] < 6'd4);
                            if (CK == 1) begin
                                if (fb[i+3] != (hi ^ lo)) ok = 1'b0;
                            end
                            if (ok) m_param[c[1:0]] = {hi, lo};
                            else    m_err = 1'b1;
                        end
                        expq.push_back(status_rd());
                    end
                end
                i += n + 1;
            end else begin
                m_en = c[0];
                if (c[1]) m_restarts++;
                expq.push_back(status_rd());
                i++;
            end
        end
    endtask

    task automatic send_bytes();
        int gap;
        obs.delete();
        fx.delete();
        fy.delete();
        foreach (fb[i]) begin
            @(posedge clk); #1;
            tests++;
            if (tx_dv !== 1'b0) begin
                fails++;
                $display("FAIL tx_dv_idle: got %b want 0", tx_dv);
            end
            rx_byte = fb[i];
            rx_dv   = 1'b1;
            fx.push_back(x);
            fy.push_back(y);
            @(posedge clk); #1;
            rx_dv = 1'b0;
            tests++;
            if (tx_dv !== 1'b1) begin
                fails++;
                $display("FAIL tx_dv_pulse: byte %0d got %b want 1", i, tx_dv);
            end
            obs.push_back(tx_byte);
            x = 16'($urandom);
            y = 16'($urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                tests++;
                if (tx_dv !== 1'b0) begin
                    fails++;
                    $display("FAIL tx_dv_gap: got %b want 0", tx_dv);
                end
            end
        end
    endtask

    task automatic check_frame(input string name);
        model_frame();
        tests++;
        if (obs.size() != expq.size()) begin
            fails++;
            $display("FAIL %s reply_count: got %0d want %0d", name, obs.size(), expq.size());
        end
        for (int j = 0; j < obs.size() && j < expq.size(); j++) begin
            tests++;
            if (obs[j] !== expq[j]) begin
                fails++;
                $display("FAIL %s reply[%0d]: got %h want %h", name, j, obs[j], expq[j]);
            end
        end
        tests++;
        if (icx !== m_param[0] || icy !== m_param[1] || k !== m_param[2] || d !== m_param[3]) begin
            fails++;
            $display("FAIL %s params: got %h %h %h %h want %h %h %h %h", name,
                     icx, icy, k, d, m_param[0], m_param[1], m_param[2], m_param[3]);
        end
        tests++;
        if (en_dda !== m_en) begin
            fails++;
            $display("FAIL %s en_dda: got %b want %b", name, en_dda, m_en);
        end
        tests++;
        if (rs_obs != m_restarts) begin
            fails++;
            $display("FAIL %s restart_cycles: got %0d want %0d", name, rs_obs, m_restarts);
        end
    endtask

    task automatic run_frame(input string name);
        spi_cs_n = 1'b0;
        repeat (3) @(posedge clk);
        send_bytes();
        @(posedge clk); #1;
        spi_cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_frame(name);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        spi_cs_n = 1'b1;
        rx_dv    = 1'b0;
        rx_byte  = 8'h00;
        x        = 16'h0000;
        y        = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (icx !== 16'hC000 || icy !== 16'h14CD || k !== 16'h14DD || d !== 16'h14DD) begin
            fails++;
            $display("FAIL reset_params: got %h %h %h %h want c000 14cd 14dd 14dd", icx, icy, k, d);
        end
        tests++;
        if (en_dda !== 1'b1 || dda_restart !== 1'b0 || tx_dv !== 1'b0 || tx_byte !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b rs=%b txdv=%b tx=%h want 1 0 0 00",
                     en_dda, dda_restart, tx_dv, tx_byte);
        end
        rst_n = 1'b1;
        model_reset();
        fb = '{8'hC1};
        run_frame("reset_status");
        tests++;
        if (obs[0] !== 8'h80) begin
            fails++;
            $display("FAIL first_status: got %h want 80", obs[0]);
        end
    endtask

    task automatic test_write_param();
        fb = '{8'h41, 8'h12, 8'h34};
        if (CK == 1) fb.push_back(8'h26);
        run_frame("write_icy");
        tests++;
        if (icy !== 16'h1234) begin
            fails++;
            $display("FAIL write_icy_value: got %h want 1234", icy);
        end
    endtask

    task automatic test_read_state();
        logic [7:0] want[4];
        want = '{8'hAB, 8'hCD, 8'h01, 8'h02};
        x  = 16'hABCD;
        y  = 16'h0102;
        fb = '{8'h00};
        for (int j = 0; j < 4 + CK; j++) fb.push_back(8'($urandom));
        run_frame("read_state");
        for (int j = 0; j < 4; j++) begin
            tests++;
            if (obs[j] !== want[j]) begin
                fails++;
                $display("FAIL read_state_const[%0d]: got %h want %h", j, obs[j], want[j]);
            end
        end
    endtask

    task automatic test_bad_index();
        fb = '{8'h47, 8'hFF, 8'hFF};
        run_frame("bad_index");
        tests++;
        if (obs[2] !== 8'h81) begin
            fails++;
            $display("FAIL bad_index_status: got %h want 81", obs[2]);
        end
        fb = '{8'hC1};
        run_frame("bad_index_clear");
        tests++;
        if (obs[0] !== 8'h80) begin
            fails++;
            $display("FAIL err_cleared_status: got %h want 80", obs[0]);
        end
    endtask

    task automatic test_control();
        fb = '{8'hC2};
        run_frame("control_stop");
        tests++;
        if (en_dda !== 1'b0 || obs[0] !== 8'h00) begin
            fails++;
            $display("FAIL control_c2: got en=%b status=%h want 0 00", en_dda, obs[0]);
        end
        fb = '{8'hC1};
        run_frame("control_run");
    endtask

    task automatic test_abort();
        fb = '{8'h42, 8'h55};
        run_frame("abort_write");
        fb = '{8'h42, 8'h9A, 8'h3C};
        if (CK == 1) fb.push_back(8'h9A ^ 8'h3C);
        run_frame("write_after_abort");
        fb = '{8'h00, 8'h11, 8'h22};
        run_frame("abort_stream");
        fb = '{8'h81, 8'h00, 8'h00};
        if (CK == 1) fb.push_back(8'h00);
        run_frame("read_after_abort");
    endtask

    task automatic test_cs_coincident();
        spi_cs_n = 1'b0;
        repeat (3) @(posedge clk);
        fb = '{8'h41, 8'h77};
        send_bytes();
        @(posedge clk); #1;
        spi_cs_n = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rx_byte = 8'h99;
        rx_dv   = 1'b1;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        tests++;
        if (tx_dv !== 1'b0) begin
            fails++;
            $display("FAIL cs_coincident_tx_dv: got %b want 0", tx_dv);
        end
        repeat (3) @(posedge clk);
        #1;
        check_frame("cs_coincident");
    endtask

    task automatic test_random();
        int         ncmd;
        int         op;
        int         cut;
        logic [7:0] c, hi, lo;
        for (int f = 0; f < 40; f++) begin
            fb.delete();
            ncmd = $urandom_range(1, 3);
            for (int n = 0; n < ncmd; n++) begin
                op = $urandom_range(0, 3);
                if ($urandom_range(0, 5) == 0) c = {2'(op), 6'($urandom)};
                else                           c = {2'(op), 4'b0, 2'($urandom)};
                fb.push_back(c);
                case (op)
                    0: for (int j = 0; j < 4 + CK; j++) fb.push_back(8'($urandom));
                    2: for (int j = 0; j < 2 + CK; j++) fb.push_back(8'($urandom));
                    1: begin
                        hi = 8'($urandom);
                        lo = 8'($urandom);
                        fb.push_back(hi);
                        fb.push_back(lo);
                        if (CK == 1) begin
                            if ($urandom_range(0, 3) == 0) fb.push_back(8'($urandom));
                            else                           fb.push_back(hi ^ lo);
                        end
                    end
                    default: ;
                endcase
            end
            if ($urandom_range(0, 4) == 0) begin
                cut = $urandom_range(1, fb.size());
                while (fb.size() > cut) void'(fb.pop_back());
            end
            run_frame("random");
        end
    endtask

    task automatic test_reset_mid_frame();
        fb = '{8'hC0};
        run_frame("pre_reset_stop");
        spi_cs_n = 1'b0;
        repeat (3) @(posedge clk);
        fb = '{8'h40, 8'hAA};
        send_bytes();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (icx !== 16'hC000 || icy !== 16'h14CD || k !== 16'h14DD || d !== 16'h14DD || en_dda !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: got %h %h %h %h en=%b want c000 14cd 14dd 14dd 1",
                     icx, icy, k, d, en_dda);
        end
        model_reset();
        spi_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fb = '{8'hC1};
        run_frame("post_reset");
        tests++;
        if (obs[0] !== 8'h80) begin
            fails++;
            $display("FAIL post_reset_status: got %h want 80", obs[0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_param();
        test_read_state();
        test_bad_index();
        test_control();
        test_abort();
        test_cs_coincident();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
